demux_rr_param: RTL and testbench
=================================

DEMUX_RR_PARAM -- requirements
Module: demux_rr_param

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, meaning the number of output channels, legal range 2..16.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning entries per channel buffer, a power of two and at least 2.

Ports (name, direction, width, meaning):
REQ-004 clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 reset, input, 1, the reset; it SHALL be asynchronous and active-high.
REQ-006 mode, input, 1, the routing mode: 0 = round-robin, 1 = explicit select.
REQ-007 dest_in, input, CW, the destination channel in select mode, where CW = max(1, clog2(NUM_CH)).
REQ-008 valid_in / data_in, input, 1 / DATA_W, the upstream word and its qualifier.
REQ-009 ready_out, output, 1, the upstream-accept indication.
REQ-010 valid_out / data_out, output, NUM_CH / NUM_CH*DATA_W, the per-channel qualifier and data; channel i data occupies bits [i*DATA_W +: DATA_W].
REQ-011 ready_in, input, NUM_CH, the per-channel downstream-accept indication.
REQ-012 err_out, output, 1, a one-cycle pulse that flags an illegal destination.

Function
REQ-013 The target channel is tgt = rr_ptr when mode=0, and tgt = dest_in when mode=1.
REQ-014 ready_out SHALL equal "channel tgt not full" when tgt < NUM_CH, and SHALL equal 1 when tgt >= NUM_CH; it SHALL be combinational with no dependence on same-cycle pops.
REQ-015 An accept occurs on a clock edge where valid_in=1 and ready_out=1; on an accept to a legal tgt, data_in SHALL be written to the tail of channel tgt.
REQ-016 On an accept where mode=1 and dest_in >= NUM_CH, the word SHALL be dropped, err_out SHALL be 1 for the following cycle, and rr_ptr SHALL be unchanged.
REQ-017 rr_ptr SHALL advance by 1 only on an accept made while mode=0, and SHALL wrap from NUM_CH-1 to 0.
REQ-018 rr_ptr SHALL hold while mode=1; returning to mode 0 SHALL resume from the held value.
REQ-019 A mode change SHALL apply to the same-cycle tgt computation, with no pipeline delay.
REQ-020 valid_out[i] SHALL equal "channel i not empty", and data_out for channel i SHALL present the head entry, registered.
REQ-021 A pop of channel i occurs on a clock edge where valid_out[i]=1 and ready_in[i]=1.
REQ-022 Latency SHALL be as follows: a word accepted at edge k is visible on valid_out/data_out after edge k, i.e. 1 cycle, when the channel was empty; there SHALL be no same-cycle bypass.
REQ-023 A simultaneous push and pop on the same non-full channel SHALL leave the occupancy unchanged and preserve order.
REQ-024 A full channel SHALL NOT accept even when it is popped in the same cycle, because of REQ-014.
REQ-025 A full channel in round-robin mode SHALL stall the input; the block SHALL NOT skip to another channel.
REQ-026 Per-channel order SHALL be FIFO, and pointers SHALL wrap modulo DEPTH.
REQ-027 Channels SHALL be independent, so a stalled ready_in[j] SHALL NOT affect channel i≠j except through REQ-025.
REQ-028 data_out for an empty channel SHALL hold its last value, or 0 if the channel has not been written since reset.

Reset
REQ-029 While reset=1, asynchronously: all channel buffers SHALL be empty, valid_out=0, data_out=0, rr_ptr=0 and err_out=0.
REQ-030 Assertion of reset mid-transfer SHALL discard all buffered words; the first accept after release SHALL go to channel 0 in mode 0.
REQ-031 ready_out SHALL be 1 during reset when tgt is legal, but no accept SHALL occur while reset=1.

Structure
REQ-032 A shared package demux_pkg SHALL hold the mode encodings (MODE_RR=0, MODE_SEL=1) and a clog2-based width helper.
REQ-033 The per-channel buffer SHALL be a sub-module demux_ch_fifo (DATA_W, DEPTH) with push, pop, full, empty and head ports, instantiated NUM_CH times by a generate loop.
REQ-034 The top level SHALL contain only tgt selection, rr_ptr, the error pulse and the push/pop decode.

Verification
REQ-035 Scenario: defaults, mode=0, all ready_in=1, valid_in=1, data_in=0x00..0x07 on consecutive edges -> channel 0 gets 0x00 and 0x04, channel 1 gets 0x01 and 0x05, channel 2 gets 0x02 and 0x06, channel 3 gets 0x03 and 0x07, each valid 1 cycle after its accept.
REQ-036 Scenario: mode=0, ready_in[1]=0, stream 0x10..0x17 -> channel 1 holds 0x11 and 0x15 (full); on the third visit to channel 1 ready_out=0 and the input stalls; raising ready_in[1] releases 0x11 first and the stream resumes.
REQ-037 Scenario: mode=1, dest_in=2, 0xAA, then dest_in=5 with NUM_CH=4, 0xBB -> 0xAA appears on channel 2; 0xBB is dropped; err_out=1 for exactly one cycle; rr_ptr is unchanged.
REQ-038 Scenario: channel 0 full with ready_in[0]=1 and a push targeting channel 0 -> ready_out=0, one pop occurs, occupancy becomes DEPTH-1, and no push happens.
REQ-039 Scenario: 3 words in flight in mode 0, reset asserted mid-cycle -> all valid_out drop immediately; after release, 0x55 lands on channel 0.
REQ-040 Scenario: mode toggling 0→1→0 with two RR accepts, then one accept with dest_in=3, then a further RR accept -> the RR words go to channels 0, 1 and 2, and the select word goes to channel 3.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the round-robin / explicit-select demultiplexer.
// Holds the routing-mode encodings and the index-width helper.
package demux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_ch_fifo.sv
// Per-channel FIFO with registered full/empty flags and a registered head word.
// The head register holds its last value once the buffer drains.
module demux_ch_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW   = idx_w(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
    full_d   = (count_d == CNTW'(DEPTH));
    empty_d  = (count_d == '0);
    head_d   = head_q;
    // The new head is the word being written when it lands in the head slot.
    if (!empty_d) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = head_q;

endmodule

// File: rtl/demux_rr_param.sv
// One-to-NUM_CH demultiplexer: round-robin or explicit destination, with a
// FIFO per output channel and a one-cycle error pulse for illegal destinations.
module demux_rr_param
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CW    = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [CW-1:0]            dest_in,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ready_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  input  logic [NUM_CH-1:0]        ready_in,
  output logic                     err_out
);

  localparam int unsigned NSLOT = 1 << CW;

  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic [CW-1:0]     tgt;
  logic              tgt_legal;
  logic              accept;
  logic [NUM_CH-1:0] full, empty, push, pop;
  logic [NSLOT-1:0]  full_pad, push_pad;

  // Target selection and upstream handshake; illegal targets always accept.
  always_comb begin
    tgt       = (mode == MODE_SEL) ? dest_in : rr_ptr_q;
    tgt_legal = (32'(tgt) < NUM_CH);
    full_pad  = '0;
    full_pad[NUM_CH-1:0] = full;
    ready_out = tgt_legal ? ~full_pad[tgt] : 1'b1;
    accept    = valid_in & ready_out & ~reset;
  end

  // Push/pop decode.
  always_comb begin
    push_pad = '0;
    if (accept && tgt_legal) begin
      push_pad[tgt] = 1'b1;
    end
    push      = push_pad[NUM_CH-1:0];
    valid_out = ~empty;
    pop       = valid_out & ready_in;
  end

  // Pointer only moves on round-robin accepts; select mode leaves it parked.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    err_d    = accept & (mode == MODE_SEL) & ~tgt_legal;
    if (accept && (mode == MODE_RR)) begin
      rr_ptr_d = (32'(rr_ptr_q) == NUM_CH - 1) ? '0 : rr_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_out = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux_ch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (data_in),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (data_out[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_rr_param.sv
// Directed bench for demux_rr_param: default instance plus a 3-channel
// instance where an out-of-range destination is encodable.
module tb_demux_rr_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_mode, a_valid_in, a_ready_out, a_err_out;
  logic [1:0]  a_dest_in;
  logic [7:0]  a_data_in;
  logic [3:0]  a_valid_out, a_ready_in;
  logic [31:0] a_data_out;

  logic        b_mode, b_valid_in, b_ready_out, b_err_out;
  logic [1:0]  b_dest_in;
  logic [7:0]  b_data_in;
  logic [2:0]  b_valid_out, b_ready_in;
  logic [23:0] b_data_out;

  int n_checks = 0;
  int n_errors = 0;

  demux_rr_param u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .mode      (a_mode),
    .dest_in   (a_dest_in),
    .valid_in  (a_valid_in),
    .data_in   (a_data_in),
    .ready_out (a_ready_out),
    .valid_out (a_valid_out),
    .data_out  (a_data_out),
    .ready_in  (a_ready_in),
    .err_out   (a_err_out)
  );

  demux_rr_param #(.DATA_W(8), .NUM_CH(3), .DEPTH(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .mode      (b_mode),
    .dest_in   (b_dest_in),
    .valid_in  (b_valid_in),
    .data_in   (b_data_in),
    .ready_out (b_ready_out),
    .valid_out (b_valid_out),
    .data_out  (b_data_out),
    .ready_in  (b_ready_in),
    .err_out   (b_err_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_mode = 1'b0; a_dest_in = '0; a_valid_in = 1'b0; a_data_in = '0; a_ready_in = '0;
    b_mode = 1'b0; b_dest_in = '0; b_valid_in = 1'b0; b_data_in = '0; b_ready_in = '0;
    #1;
    check("rst_valid", 32'(a_valid_out), 32'h0);
    check("rst_data", a_data_out, 32'h0);
    check("rst_err", 32'(a_err_out), 32'h0);
    check("rst_ready", 32'(a_ready_out), 32'h1);
    tick();
    tick();
    reset = 1'b0;

    // Round-robin distribution, every word popped one cycle after it shows up.
    a_ready_in = 4'hF;
    a_valid_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_data_in = 8'(k);
      tick();
      check($sformatf("rr_valid_%0d", k), 32'(a_valid_out), 32'(1 << (k % 4)));
      check($sformatf("rr_data_%0d", k), 32'(a_data_out[(k % 4)*8 +: 8]), 32'(k));
    end
    a_valid_in = 1'b0;
    tick();
    check("rr_drained", 32'(a_valid_out), 32'h0);
    check("rr_hold_last", a_data_out, 32'h07060504);

    // Channel 1 stalled: fills with 0x11/0x15, third visit blocks the input.
    a_ready_in = 4'b1101;
    a_valid_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      a_data_in = 8'(8'h10 + k);
      #1;
      check($sformatf("stall_rdy_%0d", k), 32'(a_ready_out), 32'h1);
      tick();
    end
    a_data_in = 8'h19;
    #1;
    check("stall_blocked", 32'(a_ready_out), 32'h0);
    check("stall_ch1_head", 32'(a_data_out[15:8]), 32'h11);
    tick();
    check("stall_hold", 32'(a_ready_out), 32'h0);
    check("stall_ch1_keep", 32'(a_data_out[15:8]), 32'h11);
    a_ready_in = 4'hF;
    #1;
    check("full_pop_no_accept", 32'(a_ready_out), 32'h0);
    tick();
    check("release_head", 32'(a_data_out[15:8]), 32'h15);
    check("release_ready", 32'(a_ready_out), 32'h1);
    tick();
    check("resume_head", 32'(a_data_out[15:8]), 32'h19);
    check("resume_valid", 32'(a_valid_out[1]), 32'h1);
    a_valid_in = 1'b0;
    tick();
    tick();
    check("stall_drained", 32'(a_valid_out), 32'h0);

    // Reset mid-flight discards buffered words; next RR word lands on channel 0.
    a_ready_in = 4'h0;
    a_valid_in = 1'b1;
    a_data_in = 8'h31; tick();
    a_data_in = 8'h32; tick();
    a_data_in = 8'h33; tick();
    check("inflight_valid", 32'(a_valid_out), 32'hD);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(a_valid_out), 32'h0);
    check("async_data", a_data_out, 32'h0);
    check("rst_ready_legal", 32'(a_ready_out), 32'h1);
    tick();
    check("rst_no_accept", 32'(a_valid_out), 32'h0);
    reset = 1'b0;
    a_ready_in = 4'hF;
    a_data_in = 8'h55;
    tick();
    check("post_rst_valid", 32'(a_valid_out), 32'h1);
    check("post_rst_data", 32'(a_data_out[7:0]), 32'h55);
    a_valid_in = 1'b0;
    tick();

    // Mode toggling: RR pointer parks while selecting and resumes afterwards.
    reset = 1'b1;
    #1 reset = 1'b0;
    a_ready_in = 4'h0;
    a_valid_in = 1'b1;
    a_mode = 1'b0;
    a_data_in = 8'h61; tick();
    a_data_in = 8'h62; tick();
    a_mode = 1'b1; a_dest_in = 2'd3; a_data_in = 8'h63;
    #1;
    check("sel_ready", 32'(a_ready_out), 32'h1);
    tick();
    a_mode = 1'b0; a_data_in = 8'h64;
    tick();
    a_valid_in = 1'b0;
    #1;
    check("toggle_valid", 32'(a_valid_out), 32'hF);
    check("toggle_data", a_data_out, 32'h63646261);

    // Full channel 0 popped while targeted: one pop, no push.
    a_mode = 1'b1; a_dest_in = 2'd0; a_valid_in = 1'b1; a_data_in = 8'h71;
    tick();
    a_data_in = 8'h72;
    #1;
    check("full_ready", 32'(a_ready_out), 32'h0);
    a_ready_in = 4'b0001;
    #1;
    check("full_ready_pop", 32'(a_ready_out), 32'h0);
    tick();
    check("full_pop_head", 32'(a_data_out[7:0]), 32'h71);
    check("full_pop_valid", 32'(a_valid_out[0]), 32'h1);
    a_valid_in = 1'b0;
    tick();
    check("full_no_push", 32'(a_valid_out[0]), 32'h0);
    check("full_hold", 32'(a_data_out[7:0]), 32'h71);

    // Illegal destination on the 3-channel instance.
    b_ready_in = 3'b000;
    b_mode = 1'b0; b_valid_in = 1'b1; b_data_in = 8'hA0;
    tick();
    b_mode = 1'b1; b_dest_in = 2'd2; b_data_in = 8'hAA;
    tick();
    check("sel_valid", 32'(b_valid_out), 32'h5);
    check("sel_data", 32'(b_data_out[23:16]), 32'hAA);
    check("sel_no_err", 32'(b_err_out), 32'h0);
    b_dest_in = 2'd3; b_data_in = 8'hBB;
    #1;
    check("bad_ready", 32'(b_ready_out), 32'h1);
    tick();
    check("bad_err", 32'(b_err_out), 32'h1);
    check("bad_dropped", 32'(b_valid_out), 32'h5);
    b_valid_in = 1'b0; b_mode = 1'b0;
    tick();
    check("err_one_cycle", 32'(b_err_out), 32'h0);
    b_valid_in = 1'b1; b_data_in = 8'hCC;
    tick();
    check("rr_kept_valid", 32'(b_valid_out), 32'h7);
    check("rr_kept_data", 32'(b_data_out[15:8]), 32'hCC);
    b_valid_in = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
